// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Iterative HI/LO multiply/divide unit for the MIPS-32 datapath. It owns the
//   architectural HI and LO registers. MULT/MULTU run a radix-2 shift-add
//   multiply and DIV/DIVU run a restoring divide. Each takes one iteration per
//   clock over WIDTH cycles, then one fix-up cycle for sign correction and the
//   HI/LO write. MTHI/MTLO write HI/LO directly from rs_data while idle.
//
// Ports
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high reset
//   start     : launch an operation (sampled only when idle)
//   op        : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   rs_data   : operand A (multiplicand / dividend), MTHI/MTLO source
//   rt_data   : operand B (multiplier / divisor)
//   hi_write  : MTHI request
//   lo_write  : MTLO request
//   busy      : operation in flight
//   done      : one-cycle pulse, HI/LO just updated
//   hi, lo    : architectural HI / LO registers
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_write,
  input  logic             lo_write,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 is_div;
  logic                 sign_a;
  logic                 sign_b;
  logic                 div_zero;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH-1:0]     rs_raw;
  // Shared working register:
  //   multiply: {partial product high half, multiplier shifting out low}
  //   divide  : {partial remainder, dividend shifting out / quotient in}
  logic [2*WIDTH-1:0]   acc;

  // Two's-complement negate when en is set.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                               input logic en);
    logic signed [WIDTH-1:0] s;
    s = $signed(v);
    return en ? $unsigned(-s) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_wide_if(input logic [2*WIDTH-1:0] v,
                                                     input logic en);
    logic signed [2*WIDTH-1:0] s;
    s = $signed(v);
    return en ? $unsigned(-s) : v;
  endfunction

  // Operand sign capture: only MULT/DIV (op[0]=0) treat operands as signed.
  logic             rs_neg;
  logic             rt_neg;
  logic [WIDTH-1:0] rs_abs;
  logic [WIDTH-1:0] rt_abs;

  always_comb begin
    rs_neg = ~op[0] & rs_data[WIDTH-1];
    rt_neg = ~op[0] & rt_data[WIDTH-1];
    rs_abs = neg_if(rs_data, rs_neg);
    rt_abs = neg_if(rt_data, rt_neg);
  end

  // One multiply iteration: conditionally add the multiplicand into the high
  // half, then shift the whole accumulator right (carry enters at the top).
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? a_mag : '0)};
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // One restoring-divide iteration: shift left, trial-subtract the divisor
  // from the remainder; keep the difference and set the quotient bit when it
  // does not borrow. The remainder stays below the divisor, so WIDTH+1 bits
  // suffice and bit WIDTH of the difference is the borrow.
  logic [2*WIDTH:0]     div_shift;
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   div_next;

  always_comb begin
    div_shift = {acc, 1'b0};
    div_trial = div_shift[2*WIDTH:WIDTH] - {1'b0, b_mag};
    if (!div_trial[WIDTH]) begin
      div_next = {div_trial[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
    end else begin
      div_next = div_shift[2*WIDTH-1:0];
    end
  end

  // Fix-up results from the final accumulator.
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  always_comb begin
    prod_fix = neg_wide_if(acc, sign_a ^ sign_b);
    quo_fix  = neg_if(acc[WIDTH-1:0], sign_a ^ sign_b);
    rem_fix  = neg_if(acc[2*WIDTH-1:WIDTH], sign_a);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      a_mag    <= '0;
      b_mag    <= '0;
      rs_raw   <= '0;
      acc      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div   <= op[1];
            sign_a   <= rs_neg;
            sign_b   <= rt_neg;
            div_zero <= op[1] & (rt_data == '0);
            a_mag    <= rs_abs;
            b_mag    <= rt_abs;
            rs_raw   <= rs_data;
            // Divide shifts the dividend out of the low half; multiply
            // shifts the multiplier out of it.
            acc      <= {{WIDTH{1'b0}}, (op[1] ? rs_abs : rt_abs)};
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= CALC;
          end else begin
            // Move-to writes; start takes priority over them.
            if (hi_write) hi <= rs_data;
            if (lo_write) lo <= rs_data;
          end
        end

        CALC: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= FIX;
          end
        end

        FIX: begin
          if (!is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (div_zero) begin
            // Divide by zero: dividend passes through as written, LO all ones.
            hi <= rs_raw;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//   Scoreboard bench for mult_div_unit. Stimulus pushes the expected HI/LO and
//   launch cycle of each operation into a queue; a monitor pops and compares
//   whenever done pulses. Expected values come from 64-bit integer arithmetic.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic         hi_write;
  logic         lo_write;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .hi_write (hi_write),
    .lo_write (lo_write),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
    string        name;
  } exp_t;

  exp_t sb[$];

  // Architectural HI/LO as the bench believes they should be.
  logic [W-1:0] cur_hi = '0;
  logic [W-1:0] cur_lo = '0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the MIPS semantics.
  task automatic model(input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, output logic [W-1:0] h,
                       output logic [W-1:0] l);
    logic [63:0] p;
    int          sa;
    int          sbv;
    sa  = a;
    sbv = b;
    p   = '0;
    h   = '0;
    l   = '0;
    case (o)
      2'd0: begin
        p = longint'(sa) * longint'(sbv);
        h = p[63:32];
        l = p[31:0];
      end
      2'd1: begin
        p = {32'd0, a} * {32'd0, b};
        h = p[63:32];
        l = p[31:0];
      end
      default: begin
        if (b == 0) begin
          h = a;
          l = 32'hFFFF_FFFF;
        end else if (o == 2'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          h = 32'd0;
          l = 32'h8000_0000;
        end else if (o == 2'd2) begin
          l = sa / sbv;
          h = sa % sbv;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endtask

  // Monitor: compares on every done pulse, and checks busy while an
  // operation is outstanding.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) continue;
      if (done) begin
        check("done_busy_excl", {63'd0, busy}, 64'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          check({e.name, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
          check({e.name, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
          check({e.name, "_latency"}, 64'(cyc - e.cyc), 64'd33);
          cur_hi = e.hi;
          cur_lo = e.lo;
        end
      end else if (sb.size() > 0) begin
        check("busy_inflight", {63'd0, busy}, 64'd1);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout actual=busy expected=idle");
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Launch one operation; mt additionally raises hi_write/lo_write with start.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic mt, input string name);
    exp_t e;
    logic [W-1:0] old_hi;
    logic [W-1:0] old_lo;
    wait_idle();
    @(negedge clk);
    old_hi   = cur_hi;
    old_lo   = cur_lo;
    start    = 1'b1;
    op       = o;
    rs_data  = a;
    rt_data  = b;
    hi_write = mt;
    lo_write = mt;
    model(o, a, b, e.hi, e.lo);
    e.name = name;
    @(posedge clk);
    #1;
    e.cyc = cyc;
    sb.push_back(e);
    start    = 1'b0;
    hi_write = 1'b0;
    lo_write = 1'b0;
    rs_data  = $urandom;
    rt_data  = $urandom;
    op       = 2'($urandom_range(0, 3));
    if (mt) begin
      check("start_wins_hi", {32'd0, hi}, {32'd0, old_hi});
      check("start_wins_lo", {32'd0, lo}, {32'd0, old_lo});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   o;
    logic         hw;
    logic         lw;

    reset    = 1'b1;
    start    = 1'b0;
    op       = 2'd0;
    rs_data  = '0;
    rt_data  = '0;
    hi_write = 1'b0;
    lo_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    reset = 1'b0;

    // Directed cases
    issue(2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, "multu_max");
    issue(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, "mult_neg");
    issue(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, "div_neg");
    issue(2'd3, 32'd100, 32'd7, 1'b0, "divu_small");
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    issue(2'd3, 32'h0000_1234, 32'd0, 1'b0, "divu_zero");
    issue(2'd2, 32'hFFFF_FF00, 32'd0, 1'b0, "div_zero");
    drain();

    // Second start and MTHI during a running MULTU 3*5
    issue(2'd1, 32'd3, 32'd5, 1'b0, "multu_3x5");
    repeat (9) @(posedge clk);
    #1;
    start    = 1'b1;
    op       = 2'd2;
    rs_data  = 32'd77;
    rt_data  = 32'd9;
    hi_write = 1'b1;
    lo_write = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("midop_hi_hold", {32'd0, hi}, {32'd0, cur_hi});
    check("midop_lo_hold", {32'd0, lo}, {32'd0, cur_lo});
    repeat (5) @(posedge clk);
    #1;
    hi_write = 1'b0;
    lo_write = 1'b0;
    check("midop_hi_hold2", {32'd0, hi}, {32'd0, cur_hi});
    drain();
    repeat (3) @(negedge clk);
    check("after_ignored_start_busy", {63'd0, busy}, 64'd0);

    // MTHI/MTLO in idle, including both at once
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a  = $urandom;
      hw = 1'($urandom_range(0, 1));
      lw = 1'($urandom_range(0, 1));
      if (i == 0) begin hw = 1'b1; lw = 1'b1; end
      rs_data  = a;
      hi_write = hw;
      lo_write = lw;
      @(posedge clk);
      #1;
      hi_write = 1'b0;
      lo_write = 1'b0;
      if (hw) cur_hi = a;
      if (lw) cur_lo = a;
      check("mt_hi", {32'd0, hi}, {32'd0, cur_hi});
      check("mt_lo", {32'd0, lo}, {32'd0, cur_lo});
    end

    // Randomized operations; some with simultaneous move-to requests
    for (int i = 0; i < 16; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      issue(o, a, b, 1'($urandom_range(0, 1)), "rand");
    end
    drain();

    // Reset in the middle of a DIVU
    issue(2'd3, 32'hDEAD_BEEF, 32'd13, 1'b0, "divu_abort");
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    reset  = 1'b0;
    cur_hi = '0;
    cur_lo = '0;
    repeat (40) @(posedge clk);

    @(negedge clk);
    rs_data  = 32'hCAFE_F00D;
    lo_write = 1'b1;
    @(posedge clk);
    #1;
    lo_write = 1'b0;
    check("mtlo_after_reset_lo", {32'd0, lo}, 64'h0000_0000_CAFE_F00D);
    check("mtlo_after_reset_hi", {32'd0, hi}, 64'd0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
